fifo_pkt_writer: RTL

Write-side packet framer sitting directly upstream of the asynchronous FIFO, entirely in the wr_clk domain. It accepts a byte stream with valid/ready/last handshake and buffers up to MAX_LEN payload bytes. It then writes a framed packet into the FIFO: a header byte, the payload, and a checksum byte. Writes are throttled by the FIFO's full flag so no byte is ever lost or duplicated.

---
 rtl/fifo_pkt_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fifo_pkt_writer.sv
// fifo_pkt_writer: write-side packet framer for the asynchronous FIFO (wr_clk domain).
// Collects up to MAX_LEN payload bytes, then emits header, payload and checksum
// into the FIFO, throttled by fifo_full. Oversize packets are truncated and the
// remainder of the input packet is discarded.
module fifo_pkt_writer #(
    parameter int unsigned MAX_LEN = 16
) (
    input  logic       wr_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_din,
    output logic [7:0] pkt_count,
    output logic [7:0] trunc_count
);

    localparam int unsigned AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [4:0]  MAX_LEN_W = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        COLLECT,
        HDR,
        PAYLOAD,
        CSUM,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  len_q, len_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  sum_q, sum_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  pkt_count_q, pkt_count_d;
    logic [7:0]  trunc_count_q, trunc_count_d;
    logic [7:0]  mem_q [MAX_LEN];

    logic        accept;
    logic [7:0]  header_w;
    logic [7:0]  csum_w;
    logic [4:0]  len_inc;

    assign s_ready     = !rst && (state_q == COLLECT || state_q == DISCARD);
    assign accept      = s_valid && s_ready;
    assign fifo_wr_en  = (state_q == HDR || state_q == PAYLOAD || state_q == CSUM) && !fifo_full;
    assign header_w    = {trunc_q, 2'b00, len_q};
    assign csum_w      = 8'h00 - (header_w + sum_q);
    assign len_inc     = len_q + 5'd1;
    assign pkt_count   = pkt_count_q;
    assign trunc_count = trunc_count_q;

    // Payload buffer: captures accepted bytes while collecting (no reset needed).
    always_ff @(posedge wr_clk) begin
        if (state_q == COLLECT && accept) begin
            mem_q[len_q[AW-1:0]] <= s_data;
        end
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state_q       <= COLLECT;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            trunc_q       <= 1'b0;
            pkt_count_q   <= '0;
            trunc_count_q <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            trunc_q       <= trunc_d;
            pkt_count_q   <= pkt_count_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    // Next-state logic; output states advance only on a cycle that writes the FIFO.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        trunc_d       = trunc_q;
        pkt_count_d   = pkt_count_q;
        trunc_count_d = trunc_count_q;
        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    len_d = len_inc;
                    sum_d = sum_q + s_data;
                    if (s_last) begin
                        trunc_d = 1'b0;
                        state_d = HDR;
                    end else if (len_inc == MAX_LEN_W) begin
                        trunc_d = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (fifo_wr_en) begin
                    idx_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (fifo_wr_en) begin
                    if (idx_q == len_q - 5'd1) begin
                        state_d = CSUM;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            CSUM: begin
                if (fifo_wr_en) begin
                    pkt_count_d   = pkt_count_q + 8'd1;
                    trunc_count_d = trunc_count_q + {7'b0, trunc_q};
                    state_d       = trunc_q ? DISCARD : COLLECT;
                    len_d         = '0;
                    sum_d         = '0;
                    idx_d         = '0;
                    trunc_d       = 1'b0;
                end
            end
            DISCARD: begin
                if (accept && s_last) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // FIFO write data mux selected by the current output state.
    always_comb begin
        fifo_din = '0;
        unique case (state_q)
            HDR:     fifo_din = header_w;
            PAYLOAD: fifo_din = mem_q[idx_q[AW-1:0]];
            CSUM:    fifo_din = csum_w;
            default: fifo_din = '0;
        endcase
    end

endmodule
